// File: rtl/synth_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
package synth_pkg;

    localparam int NOTE_W         = 7;
    localparam int NUM_VOICES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        GAP    = 2'd2,
        COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/voice_pick.sv
// Combinational candidate search: lowest-index matching voice, lowest-index free voice,
// and the voice holding the oldest rank.
module voice_pick #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    input  logic [NUM_VOICES-1:0]        voice_key,
    input  logic [NUM_VOICES*IDX_W-1:0]  rank,
    input  logic [NOTE_W-1:0]            note,
    output logic [IDX_W-1:0]             match_idx,
    output logic                         match_found,
    output logic [IDX_W-1:0]             free_idx,
    output logic                         free_found,
    output logic [IDX_W-1:0]             oldest_idx,
    output logic                         oldest_found
);

    // Scan from the top down so the lowest index is the last writer and wins.
    always_comb begin
        match_idx    = '0;
        match_found  = 1'b0;
        free_idx     = '0;
        free_found   = 1'b0;
        oldest_idx   = '0;
        oldest_found = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voice_key[v] && (voice_note[v*NOTE_W +: NOTE_W] == note)) begin
                match_idx   = IDX_W'(v);
                match_found = 1'b1;
            end
            if (!voice_key[v]) begin
                free_idx   = IDX_W'(v);
                free_found = 1'b1;
            end
            if (rank[v*IDX_W +: IDX_W] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_idx   = IDX_W'(v);
                oldest_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Note-event to voice allocator with retrigger/steal handling and LRU ranking.
// state  | meaning
// IDLE   | ev_ready high, waiting for an event
// SEARCH | pick match/free/oldest; note-off resolves here
// GAP    | target key held low one cycle so the envelope restarts
// COMMIT | target note/key written on entry; returns to IDLE
module voice_alloc #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES_DEF,
    parameter int NOTE_W     = synth_pkg::NOTE_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ev_valid,
    output logic                                ev_ready,
    input  logic                                ev_on,
    input  logic [NOTE_W-1:0]                   ev_note,
    output logic [NUM_VOICES*NOTE_W-1:0]        voice_note,
    output logic [NUM_VOICES-1:0]               voice_key,
    output logic                                steal,
    output logic [$clog2(NUM_VOICES):0]         active_cnt
);
    import synth_pkg::*;

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES) + 1;

    state_e                       state_q, state_d;
    logic                         on_q, on_d;
    logic [NOTE_W-1:0]            note_q, note_d;
    logic [IDX_W-1:0]             tgt_q, tgt_d;
    logic                         steal_pend_q, steal_pend_d;
    logic [NUM_VOICES*NOTE_W-1:0] vnote_q, vnote_d;
    logic [NUM_VOICES-1:0]        key_q, key_d;
    logic [NUM_VOICES*IDX_W-1:0]  rank_q, rank_d;
    logic                         steal_q, steal_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic                         commit_en;
    logic [IDX_W-1:0]             commit_idx;
    logic                         commit_steal;
    logic [IDX_W-1:0]             commit_rank;

    logic [IDX_W-1:0]             match_idx, free_idx, oldest_idx;
    logic                         match_found, free_found, oldest_found;

    voice_pick #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_W     (NOTE_W),
        .IDX_W      (IDX_W)
    ) u_pick (
        .voice_note   (vnote_q),
        .voice_key    (key_q),
        .rank         (rank_q),
        .note         (note_q),
        .match_idx    (match_idx),
        .match_found  (match_found),
        .free_idx     (free_idx),
        .free_found   (free_found),
        .oldest_idx   (oldest_idx),
        .oldest_found (oldest_found)
    );

    always_comb begin
        state_d      = state_q;
        on_d         = on_q;
        note_d       = note_q;
        tgt_d        = tgt_q;
        steal_pend_d = steal_pend_q;
        vnote_d      = vnote_q;
        key_d        = key_q;
        rank_d       = rank_q;
        steal_d      = 1'b0;
        commit_en    = 1'b0;
        commit_idx   = tgt_q;
        commit_steal = steal_pend_q;
        commit_rank  = '0;
        cnt_d        = '0;

        case (state_q)
            IDLE: begin
                if (ev_valid) begin
                    on_d    = ev_on;
                    note_d  = ev_note;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (!on_q) begin
                    if (match_found) key_d[match_idx] = 1'b0;
                    state_d = IDLE;
                end else if (match_found) begin
                    key_d[match_idx] = 1'b0;
                    tgt_d            = match_idx;
                    steal_pend_d     = 1'b0;
                    state_d          = GAP;
                end else if (free_found) begin
                    commit_en    = 1'b1;
                    commit_idx   = free_idx;
                    commit_steal = 1'b0;
                    state_d      = COMMIT;
                end else if (oldest_found) begin
                    key_d[oldest_idx] = 1'b0;
                    tgt_d             = oldest_idx;
                    steal_pend_d      = 1'b1;
                    state_d           = GAP;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                commit_en = 1'b1;
                state_d   = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Writes land on the edge into COMMIT so the COMMIT cycle shows the new voice.
        if (commit_en) begin
            commit_rank = rank_q[int'(commit_idx)*IDX_W +: IDX_W];
            vnote_d[int'(commit_idx)*NOTE_W +: NOTE_W] = note_q;
            key_d[commit_idx] = 1'b1;
            steal_d           = commit_steal;
            tgt_d             = commit_idx;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (rank_q[v*IDX_W +: IDX_W] < commit_rank)
                    rank_d[v*IDX_W +: IDX_W] = rank_q[v*IDX_W +: IDX_W] + IDX_W'(1);
            end
            rank_d[int'(commit_idx)*IDX_W +: IDX_W] = '0;
        end

        for (int v = 0; v < NUM_VOICES; v++) cnt_d = cnt_d + CNT_W'(key_d[v]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            on_q         <= 1'b0;
            note_q       <= '0;
            tgt_q        <= '0;
            steal_pend_q <= 1'b0;
            vnote_q      <= '0;
            key_q        <= '0;
            steal_q      <= 1'b0;
            cnt_q        <= '0;
            for (int v = 0; v < NUM_VOICES; v++)
                rank_q[v*IDX_W +: IDX_W] <= IDX_W'(NUM_VOICES - 1 - v);
        end else begin
            state_q      <= state_d;
            on_q         <= on_d;
            note_q       <= note_d;
            tgt_q        <= tgt_d;
            steal_pend_q <= steal_pend_d;
            vnote_q      <= vnote_d;
            key_q        <= key_d;
            rank_q       <= rank_d;
            steal_q      <= steal_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ev_ready   = (state_q == IDLE);
    assign voice_note = vnote_q;
    assign voice_key  = key_q;
    assign steal      = steal_q;
    assign active_cnt = cnt_q;

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NUM_VOICES, default 4, SHALL set the number of voices driven; legal values are 2, 4 and 8.
REQ-002 Parameter NOTE_W, default 7, SHALL set the note-number width, which is the note-ROM address width.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 ev_valid  input  1  SHALL indicate that a note event is offered.
REQ-006 ev_ready  output  1  SHALL indicate that voice_alloc accepts an event this cycle.
REQ-007 ev_on  input  1  SHALL mark the event type: 1 = note-on, 0 = note-off.
REQ-008 ev_note  input  NOTE_W  SHALL carry the note number.
REQ-009 voice_note  output  NUM_VOICES*NOTE_W  SHALL carry each voice's note; slice v is voice v's F_in.
REQ-010 voice_key  output  NUM_VOICES  SHALL carry each voice's key_on gate.
REQ-011 steal  output  1  SHALL pulse for one cycle when a busy voice is reassigned.
REQ-012 active_cnt  output  $clog2(NUM_VOICES)+1  SHALL report the number of voices with voice_key=1.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SEARCH, GAP and COMMIT.
REQ-014 ev_ready SHALL be 1 only in IDLE; ev_valid & ev_ready SHALL latch ev_on and ev_note, and the FSM SHALL enter SEARCH.
REQ-015 SEARCH (one cycle) SHALL compute three candidates from registered state:
  - match: lowest-index voice with voice_key=1 and voice_note=latched note;
  - free: lowest-index voice with voice_key=0;
  - oldest: the voice with rank=NUM_VOICES-1.
REQ-016 For a note-off in SEARCH with a match, that voice's voice_key SHALL clear at the next edge and the FSM SHALL return to IDLE.
REQ-017 For a note-off in SEARCH with no match, the event SHALL be discarded with no state change, and the FSM SHALL return to IDLE.
REQ-018 For a note-on, the target voice SHALL be chosen in priority order match > free > oldest.
REQ-019 If the target is a free voice, the FSM SHALL go SEARCH->COMMIT.
REQ-020 If the target is a match (retrigger) or the oldest voice (steal), its voice_key SHALL clear and the FSM SHALL go SEARCH->GAP->COMMIT, guaranteeing key_on is low for exactly one cycle so the envelope restarts.
REQ-021 In COMMIT, the target's voice_note SHALL load the latched note and its voice_key SHALL set; the FSM SHALL then return to IDLE.
REQ-022 steal SHALL pulse in COMMIT only for the oldest-voice case, not for a retrigger.
REQ-023 Each voice SHALL hold a rank in 0..NUM_VOICES-1, with all ranks distinct at all times.
REQ-024 On COMMIT to voice t, every voice with rank < rank[t] SHALL increment its rank, and rank[t] SHALL become 0.
REQ-025 Note-off SHALL NOT alter ranks.
REQ-026 Latency from event acceptance to voice_key change SHALL be:
  - 2 cycles for a note-off or a free-voice note-on;
  - 3 cycles for a retrigger or steal.
REQ-027 The minimum event spacing SHALL be 3 cycles (free) or 4 cycles (retrigger/steal); ev_ready SHALL reassert in the cycle after COMMIT or after SEARCH for a note-off.
REQ-028 voice_note SHALL hold its value after note-off so the release tail keeps its pitch.
REQ-029 active_cnt SHALL be the registered population count of voice_key, updated in the same cycle as voice_key.

Reset
REQ-030 While Reset=0, the block SHALL hold: FSM=IDLE, voice_key=0, voice_note=0, steal=0, active_cnt=0, rank[v]=NUM_VOICES-1-v (voice 0 oldest), and latched event cleared.
REQ-031 Reset asserted mid-transaction (SEARCH/GAP/COMMIT) SHALL abort the event immediately with no partial write visible after release.
REQ-032 ev_ready SHALL be 1 in the first cycle after Reset deasserts.

Structure
REQ-033 A shared package synth_pkg SHALL hold the FSM state enum (IDLE, SEARCH, GAP, COMMIT), NOTE_W and the default NUM_VOICES.
REQ-034 A single sub-module voice_pick SHALL implement the combinational match/free/oldest priority search, returning index and found flags.
REQ-035 voice_note and voice_key SHALL connect directly to per-voice F_in and key_on with no added register stage.

Verification
REQ-036 After reset, note-on 60 then note-on 64 -> voice0=60 and voice1=64 with key=1, active_cnt=2, steal never pulses.
REQ-037 Four voices busy with notes 60, 62, 64, 65 in that order, then note-on 67 -> voice0 key drops for exactly 1 cycle, voice0=67, steal=1 for one cycle.
REQ-038 Voice1 holds 62 with key=1, then note-on 62 -> voice1 key low 1 cycle then high, no other voice changes, steal=0, voice1 rank becomes 0.
REQ-039 Note-off 62 while 62 is active -> voice1 key=0 two cycles after acceptance, voice1 note stays 62; note-off 70 when 70 is not active -> no output change.
REQ-040 ev_valid held high with alternating on/off events -> ev_ready low in SEARCH/GAP/COMMIT, no event lost or duplicated, accepted-event count matches the scoreboard.
REQ-041 Reset pulsed during GAP -> all keys=0 and ranks restored; a subsequent note-on 60 lands on voice0.
